// File: rtl/burst_mode_framer.sv
// burst_mode_framer
//   Upstream burst-mode transmitter for a 32-bit datapath. Each burst is
//   built as: ON_WORDS idle words (laser settling), PREAMBLE_WORDS preamble
//   words, one syncword, the payload words pulled through a valid/ready
//   handshake, then TAIL_WORDS idle words. The total burst length is fixed
//   by the latched length, so a missing payload word does not shorten it.
//
// Ports
//   in_clock      datapath clock, one word per cycle
//   rst           synchronous reset, active-low
//   in_start      burst request, sampled only in IDLE
//   in_length     payload length in words (latched on accepted start)
//   in_preamble   preamble word (latched on accepted start)
//   in_syncword   syncword (latched on accepted start, sent unmodified)
//   in_data       payload word
//   in_data_valid payload word valid
//   in_data_ready payload word accepted this cycle (state-only, no valid path)
//   out_data      registered transmit word
//   out_burst_en  registered laser/burst enable
//   out_sof       one-cycle flag aligned with the syncword on out_data
//   out_busy      high whenever the FSM is not in IDLE
//   out_done      one-cycle pulse aligned with the last tail word
//   out_underrun  sticky payload-underrun flag, cleared on the next start
module burst_mode_framer #(
  parameter int ON_WORDS       = 4,
  parameter int PREAMBLE_WORDS = 8,
  parameter int TAIL_WORDS     = 2,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                 in_clock,
  input  logic                 rst,
  input  logic                 in_start,
  input  logic [LEN_WIDTH-1:0] in_length,
  input  logic [31:0]          in_preamble,
  input  logic [31:0]          in_syncword,
  input  logic [31:0]          in_data,
  input  logic                 in_data_valid,
  output logic                 in_data_ready,
  output logic [31:0]          out_data,
  output logic                 out_burst_en,
  output logic                 out_sof,
  output logic                 out_busy,
  output logic                 out_done,
  output logic                 out_underrun
);

  // One shared down-counter: wide enough for the 8-bit phase counts and
  // for the payload length.
  localparam int CW = (LEN_WIDTH > 8) ? LEN_WIDTH : 8;

  localparam logic [CW-1:0] ON_CNT   = CW'(ON_WORDS);
  localparam logic [CW-1:0] PRE_CNT  = CW'(PREAMBLE_WORDS);
  localparam logic [CW-1:0] TAIL_CNT = CW'(TAIL_WORDS);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LASER_ON,
    S_PREAMBLE,
    S_SYNC,
    S_PAYLOAD,
    S_TAIL
  } state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [LEN_WIDTH-1:0]   length_reg, length_next;
  logic [31:0]            preamble_reg, preamble_next;
  logic [31:0]            sync_reg, sync_next;
  logic [31:0]            data_reg, data_next;
  logic                   burst_en_reg, burst_en_next;
  logic                   sof_reg, sof_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic                   underrun_reg, underrun_next;

  // Ready depends on state only so the upstream source never sees a
  // combinational loop through its own valid.
  assign in_data_ready = (state_reg == S_PAYLOAD) & rst;

  assign out_data     = data_reg;
  assign out_burst_en = burst_en_reg;
  assign out_sof      = sof_reg;
  assign out_busy     = busy_reg;
  assign out_done     = done_reg;
  assign out_underrun = underrun_reg;

  always_ff @(posedge in_clock) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      length_reg   <= '0;
      preamble_reg <= '0;
      sync_reg     <= '0;
      data_reg     <= '0;
      burst_en_reg <= 1'b0;
      sof_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      length_reg   <= length_next;
      preamble_reg <= preamble_next;
      sync_reg     <= sync_next;
      data_reg     <= data_next;
      burst_en_reg <= burst_en_next;
      sof_reg      <= sof_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      underrun_reg <= underrun_next;
    end
  end

  // Next-state and output word. The word/enable computed here belong to the
  // current state and appear on the outputs one cycle later; this is what
  // lines out_done up with the last tail word.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    length_next   = length_reg;
    preamble_next = preamble_reg;
    sync_next     = sync_reg;
    data_next     = '0;
    burst_en_next = 1'b0;
    sof_next      = 1'b0;
    done_next     = 1'b0;
    underrun_next = underrun_reg;

    case (state_reg)
      S_IDLE: begin
        if (in_start) begin
          length_next   = in_length;
          preamble_next = in_preamble;
          sync_next     = in_syncword;
          underrun_next = 1'b0;
          state_next    = S_LASER_ON;
          cnt_next      = ON_CNT;
        end
      end

      S_LASER_ON: begin
        burst_en_next = 1'b1;
        if (cnt_reg == ONE_CNT) begin
          state_next = S_PREAMBLE;
          cnt_next   = PRE_CNT;
        end else begin
          cnt_next = cnt_reg - ONE_CNT;
        end
      end

      S_PREAMBLE: begin
        burst_en_next = 1'b1;
        data_next     = preamble_reg;
        if (cnt_reg == ONE_CNT) begin
          state_next = S_SYNC;
          cnt_next   = ONE_CNT;
        end else begin
          cnt_next = cnt_reg - ONE_CNT;
        end
      end

      S_SYNC: begin
        burst_en_next = 1'b1;
        data_next     = sync_reg;
        sof_next      = 1'b1;
        // Zero-length bursts skip the payload phase entirely.
        if (length_reg == '0) begin
          state_next = S_TAIL;
          cnt_next   = TAIL_CNT;
        end else begin
          state_next = S_PAYLOAD;
          cnt_next   = CW'(length_reg);
        end
      end

      S_PAYLOAD: begin
        burst_en_next = 1'b1;
        // A missing word is replaced by zero; the counter still advances so
        // the burst keeps its slot length.
        if (in_data_valid) begin
          data_next = in_data;
        end else begin
          underrun_next = 1'b1;
        end
        if (cnt_reg == ONE_CNT) begin
          state_next = S_TAIL;
          cnt_next   = TAIL_CNT;
        end else begin
          cnt_next = cnt_reg - ONE_CNT;
        end
      end

      S_TAIL: begin
        burst_en_next = 1'b1;
        if (cnt_reg == ONE_CNT) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - ONE_CNT;
        end
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Busy is registered together with the state register.
  assign busy_next = (state_next != S_IDLE);

endmodule

// File: doc/burst_mode_framer.md
Name: burst_mode_framer

Overview:
Upstream burst-mode transmitter that builds each upstream burst on the 32-bit datapath. It pairs with the receive-side syncword synchronizer. Each burst is built in this order: laser turn-on idle words, preamble, one syncword, payload words pulled through a valid/ready handshake, then a laser turn-off tail. It drives the serializer data bus and the optical transmitter burst-enable, with fixed burst timing suitable for TDMA slots.

Parameters:
ON_WORDS, 4, number of idle words (0x00000000) sent with burst enable high before the preamble (laser settling); legal range 1-255.
PREAMBLE_WORDS, 8, number of preamble words sent before the syncword; legal range 1-255.
TAIL_WORDS, 2, number of idle words sent with burst enable high after the payload; legal range 1-255.
LEN_WIDTH, 16, width of the payload length field, in words.

Ports:
in_clock  input  1  datapath clock; one 32-bit word per cycle.
rst  input  1  synchronous reset, active-low.
in_start  input  1  burst request pulse; sampled only in IDLE.
in_length  input  LEN_WIDTH  payload length in words; latched on an accepted start.
in_preamble  input  32  preamble word; latched on an accepted start.
in_syncword  input  32  syncword; latched on an accepted start and sent unmodified.
in_data  input  32  payload word.
in_data_valid  input  1  payload word valid.
in_data_ready  output  1  payload word accepted this cycle.
out_data  output  32  registered transmit word.
out_burst_en  output  1  registered laser/burst enable.
out_sof  output  1  one-cycle flag aligned with the syncword on out_data.
out_busy  output  1  high whenever the FSM is not in IDLE.
out_done  output  1  one-cycle pulse when the burst completes.
out_underrun  output  1  sticky payload-underrun flag; cleared on the next accepted start or on reset.

Behaviour:
- Reset: rst=0 at a clock edge forces, at that same edge:
  - state to IDLE and all counters to 0;
  - out_data=0, out_burst_en=0, out_sof=0, out_busy=0, out_done=0, out_underrun=0.
  - Reset mid-burst aborts immediately; no tail words are sent.
  - in_data_ready is 0 while rst=0.
- FSM states: IDLE -> LASER_ON -> PREAMBLE -> SYNC -> PAYLOAD -> TAIL -> IDLE.
- IDLE: when in_start=1, latch in_length, in_preamble and in_syncword, clear out_underrun, then go to LASER_ON. in_start in any other state is ignored (no queuing).
- State durations:
  - LASER_ON: ON_WORDS cycles.
  - PREAMBLE: PREAMBLE_WORDS cycles.
  - SYNC: 1 cycle.
  - PAYLOAD: latched length cycles.
  - TAIL: TAIL_WORDS cycles.
  - in_length=0 goes SYNC -> TAIL directly.
  - One down-counter (8 bits, or LEN_WIDTH bits in PAYLOAD) is reloaded on every state entry.
- Word per state: LASER_ON=0, PREAMBLE=preamble, SYNC=syncword, PAYLOAD=payload word, TAIL=0, IDLE=0.
- in_data_ready = (state==PAYLOAD) & rst. It is combinational from state only, never from in_data_valid.
- Payload underrun: if in_data_valid=0 in a PAYLOAD cycle:
  - substitute 0x00000000 for that word;
  - set out_underrun;
  - still decrement the counter, so burst length stays fixed.
- Output pipeline: out_data, out_burst_en and out_sof are registered from the current state and word, giving 1 cycle of latency after the state register. For a start sampled at edge N:
  - state enters LASER_ON at edge N+1;
  - out_burst_en rises at edge N+2;
  - out_burst_en stays high for exactly ON_WORDS+PREAMBLE_WORDS+1+L+TAIL_WORDS cycles;
  - out_data=0 whenever out_burst_en=0.
- out_sof=1 only in the single cycle where out_data holds the syncword.
- out_busy = state!=IDLE, registered with the state.
- out_done: one-cycle pulse on the edge where TAIL exits to IDLE. It is high in the same cycle as the last tail word on out_data.
- Back-to-back bursts: a start sampled in the cycle after out_done is accepted. The minimum gap with out_burst_en low between bursts is 1 cycle.
- Word order: earlier cycle = earlier-transmitted word. The syncword is not bit-reversed, so a receiver at zero bit shift matches it exactly.

Test Plan:
- Defaults, preamble 0x55555555, sync 0xB2C50FA1, L=3, payload 0x11111111/0x22222222/0x33333333 always valid -> out_burst_en high for 18 cycles; out_data sequence is 4x0, 8x0x55555555, 0xB2C50FA1 with out_sof=1, the 3 payload words, 2x0; out_done high with the last 0; out_underrun=0.
- L=0 -> out_burst_en high for 15 cycles; in_data_ready never asserted; syncword is followed directly by 2x0.
- L=4 with in_data_valid dropped in the 2nd payload cycle -> 2nd payload word is 0x00000000; remaining words are shifted by none; burst still 19 cycles; out_underrun=1 after the burst; cleared on the next start.
- in_start pulsed during PREAMBLE and again in the cycle after out_done -> the first is ignored; the second starts a new burst with out_burst_en low for exactly 1 cycle between bursts.
- rst=0 asserted in the 2nd PAYLOAD cycle -> at that edge out_burst_en=0, out_data=0, out_busy=0, with no tail and no out_done; a new start after rst=1 produces a full, correct burst.
- Change in_syncword/in_preamble mid-burst to 0xFFFFFFFF -> the transmitted words keep the values latched at start.
